bsr_sipo_rx: RTL and testbench
==============================

BSR_SIPO_RX -- requirements
Module: bsr_sipo_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port sin, input, 1 bit, the serial data bit.
REQ-005 The block SHALL have port sin_en, input, 1 bit, qualifying sin as valid in this cycle.
REQ-006 The block SHALL have port mode, input, 1 bit: 1 = left shift (MSB-first stream), 0 = right shift (LSB-first stream).
REQ-007 The block SHALL have port clr, input, 1 bit, a synchronous frame abort.
REQ-008 The block SHALL have port pout, output, WIDTH bits, the last completed parallel word.
REQ-009 The block SHALL have port pout_valid, output, 1 bit, a one-cycle strobe marking a new pout.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a frame is partially received.

Function
REQ-011 The FSM SHALL have exactly the states IDLE and SHIFT.
REQ-012 In IDLE with sin_en=1, the block SHALL latch mode into frame_mode, shift in sin, set the bit count to 1, and enter SHIFT.
REQ-013 In SHIFT with sin_en=1, the block SHALL shift in sin using frame_mode and increment the bit count.
REQ-014 Left shift SHALL insert the new bit at bit 0, move existing bits toward the MSB and discard the old MSB.
REQ-015 Right shift SHALL insert the new bit at bit WIDTH-1, move existing bits toward the LSB and discard the old LSB.
REQ-016 Changes on mode while in SHIFT SHALL be ignored until the next frame start.
REQ-017 In any state, sin_en=0 SHALL hold the shift register, the bit count and the state unchanged (gaps allowed).
REQ-018 On the edge that samples the WIDTH-th bit, the block SHALL load pout with the assembled word, set pout_valid=1 for exactly one cycle, clear the count and return to IDLE (zero-cycle latency after the last bit).
REQ-019 Back-to-back frames SHALL be accepted with no idle cycle: a sin_en=1 in the cycle after completion starts a new frame.
REQ-020 pout SHALL hold its value between completions; partial frames SHALL never be visible on pout.
REQ-021 clr=1 SHALL return the FSM to IDLE, zero the count and the shift register, and force pout_valid=0, while leaving pout unchanged.
REQ-022 clr SHALL take priority over sin_en in the same cycle, so the bit presented with clr is dropped.
REQ-023 busy SHALL equal (state == SHIFT).
REQ-024 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH.

Reset
REQ-025 While rst=0, the block SHALL immediately drive pout=0, pout_valid=0 and busy=0, and set state=IDLE, count=0, shift register=0 and frame_mode=1.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame, and no pout_valid SHALL follow.
REQ-027 After rst deasserts, the first sin_en=1 SHALL be treated as bit 1 of a new frame.

Structure
REQ-028 Package bsr_pkg SHALL hold the state enum {IDLE, SHIFT} and the constants MODE_LEFT=1 and MODE_RIGHT=0.
REQ-029 The bit counter SHALL be a sub-module, bsr_bit_counter, with inputs inc and clr, output done, and parameter WIDTH.
REQ-030 The remaining logic (FSM, shift register, output register) SHALL stay in bsr_sipo_rx.

Verification (WIDTH=4)
REQ-031 Left-shift case: mode=1, sin=1,0,1,1 on 4 consecutive sin_en cycles -> pout=4'b1011 with pout_valid high for 1 cycle after the 4th edge.
REQ-032 Right-shift case: mode=0, sin=1,1,1,0 -> pout=4'b0111 with a single pout_valid pulse.
REQ-033 Gaps and mode latching: bits 1,0 then 3 idle cycles, mode toggled during the gap, then bits 1,1 -> pout=4'b1011 (mode=1 latched), busy high from bit 1 until completion.
REQ-034 Back-to-back frames: 8 consecutive sin_en cycles carrying 1011 then 0110 with mode=1 -> two pulses 4 cycles apart, pout=1011 then 0110.
REQ-035 Abort: clr asserted after 2 bits, then 4 bits 0,0,1,1 -> no pulse at the abort, then pout=4'b0011; the pout value from before the abort is held throughout.
REQ-036 Async reset: rst=0 mid-frame, asynchronous to clk -> outputs zero immediately, no pout_valid pulse, and the next 4 bits form a fresh word.

Source files
------------

// File: rtl/bsr_pkg.sv
// Shared types and constants for the serial-in, parallel-out receiver.
// The frame FSM state type and the shift-direction encodings live here.
package bsr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bsr_state_e;

    localparam logic MODE_LEFT  = 1'b1;
    localparam logic MODE_RIGHT = 1'b0;

endpackage

// File: rtl/bsr_bit_counter.sv
// Counts accepted bits of a frame and flags the edge that takes in the final bit.
// The count wraps to zero on that edge, so it never reaches WIDTH.
module bsr_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    assign done = inc && (count == LAST);

    always_comb begin
        count_next = count;
        if (clr || done) begin
            count_next = '0;
        end else if (inc) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/bsr_sipo_rx.sv
// Serial-in, parallel-out receiver: assembles WIDTH-bit frames from a gated bit stream.
// The shift direction is chosen by mode at the first bit and held for the whole frame.
module bsr_sipo_rx
    import bsr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             mode,
    input  logic             clr,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic             busy
);

    bsr_state_e       state;
    bsr_state_e       state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] pout_next;
    logic             pout_valid_next;
    logic             frame_mode;
    logic             frame_mode_next;
    logic             cur_mode;
    logic             inc;
    logic             done;

    // clr wins over sin_en, so the bit presented alongside clr is never counted.
    assign inc  = sin_en && !clr;
    assign busy = (state == SHIFT);

    bsr_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .inc (inc),
        .clr (clr),
        .done(done)
    );

    // The first bit of a frame uses the live mode; later bits use the latched one.
    assign cur_mode = (state == IDLE) ? mode : frame_mode;
    assign shifted  = (cur_mode == MODE_LEFT) ? {shreg[WIDTH-2:0], sin}
                                              : {sin, shreg[WIDTH-1:1]};

    always_comb begin
        state_next      = state;
        shreg_next      = shreg;
        frame_mode_next = frame_mode;
        pout_next       = pout;
        pout_valid_next = 1'b0;
        if (clr) begin
            state_next = IDLE;
            shreg_next = '0;
        end else if (sin_en) begin
            if (state == IDLE) begin
                frame_mode_next = mode;
            end
            if (done) begin
                state_next      = IDLE;
                shreg_next      = '0;
                pout_next       = shifted;
                pout_valid_next = 1'b1;
            end else begin
                state_next = SHIFT;
                shreg_next = shifted;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            frame_mode <= MODE_LEFT;
            pout       <= '0;
            pout_valid <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            frame_mode <= frame_mode_next;
            pout       <= pout_next;
            pout_valid <= pout_valid_next;
        end
    end

endmodule

// File: tb/tb_bsr_sipo_rx.sv
// Directed bench for bsr_sipo_rx at WIDTH=4 with hand-computed expected words.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_bsr_sipo_rx;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             sin;
    logic             sin_en;
    logic             mode;
    logic             clr;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             busy;

    int errors = 0;
    int checks = 0;

    bsr_sipo_rx #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_en    (sin_en),
        .mode      (mode),
        .clr       (clr),
        .pout      (pout),
        .pout_valid(pout_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given serial inputs, ending just after the edge.
    task automatic cyc(input logic en, input logic b);
        sin_en = en;
        sin    = b;
        @(posedge clk);
        #1;
        sin_en = 1'b0;
    endtask

    initial begin
        logic [3:0] bits;
        int         pulses;

        rst    = 1'b0;
        sin    = 1'b0;
        sin_en = 1'b0;
        mode   = 1'b1;
        clr    = 1'b0;
        #1;
        check("reset_pout", 32'(pout), 32'h0);
        check("reset_valid", 32'(pout_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Left shift, MSB first: 1,0,1,1 -> 1011
        mode = 1'b1;
        bits = 4'b1011;
        for (int i = 3; i >= 1; i--) begin
            cyc(1'b1, bits[i]);
            check("left_busy", 32'(busy), 32'h1);
            check("left_novalid", 32'(pout_valid), 32'h0);
            check("left_pout_held", 32'(pout), 32'h0);
        end
        cyc(1'b1, bits[0]);
        check("left_valid", 32'(pout_valid), 32'h1);
        check("left_pout", 32'(pout), 32'hb);
        check("left_idle", 32'(busy), 32'h0);
        cyc(1'b0, 1'b0);
        check("left_one_pulse", 32'(pout_valid), 32'h0);
        check("left_hold", 32'(pout), 32'hb);

        // Right shift, LSB first: 1,1,1,0 -> 0111
        mode = 1'b0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check("right_partial_hidden", 32'(pout), 32'hb);
        cyc(1'b1, 1'b0);
        check("right_valid", 32'(pout_valid), 32'h1);
        check("right_pout", 32'(pout), 32'h7);
        cyc(1'b0, 1'b0);
        check("right_one_pulse", 32'(pout_valid), 32'h0);

        // Gaps with mode toggled mid-frame: latched left shift -> 1011
        mode = 1'b1;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1);
            check("gap_busy", 32'(busy), 32'h1);
            check("gap_novalid", 32'(pout_valid), 32'h0);
        end
        cyc(1'b1, 1'b1);
        check("gap_busy_bit3", 32'(busy), 32'h1);
        cyc(1'b1, 1'b1);
        check("gap_valid", 32'(pout_valid), 32'h1);
        check("gap_pout", 32'(pout), 32'hb);
        check("gap_idle", 32'(busy), 32'h0);

        // Back-to-back frames 1011 then 0110, no idle between
        mode   = 1'b1;
        pulses = 0;
        bits   = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            cyc(1'b1, bits[i]);
            if (pout_valid) pulses++;
        end
        check("b2b_pout1", 32'(pout), 32'hb);
        check("b2b_valid1", 32'(pout_valid), 32'h1);
        bits = 4'b0110;
        for (int i = 3; i >= 0; i--) begin
            cyc(1'b1, bits[i]);
            if (pout_valid) pulses++;
            if (i == 3) check("b2b_busy_next", 32'(busy), 32'h1);
        end
        check("b2b_pout2", 32'(pout), 32'h6);
        check("b2b_valid2", 32'(pout_valid), 32'h1);
        check("b2b_pulses", 32'(pulses), 32'h2);

        // Abort after 2 bits; clr also drops the bit presented with it
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        clr = 1'b1;
        cyc(1'b1, 1'b1);
        clr = 1'b0;
        check("abort_novalid", 32'(pout_valid), 32'h0);
        check("abort_idle", 32'(busy), 32'h0);
        check("abort_pout_held", 32'(pout), 32'h6);
        bits = 4'b0011;
        for (int i = 3; i >= 1; i--) begin
            cyc(1'b1, bits[i]);
            check("abort_refill_novalid", 32'(pout_valid), 32'h0);
            check("abort_refill_hold", 32'(pout), 32'h6);
        end
        cyc(1'b1, bits[0]);
        check("abort_valid", 32'(pout_valid), 32'h1);
        check("abort_pout", 32'(pout), 32'h3);

        // Asynchronous reset mid-frame, applied and released between edges
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("areset_pout", 32'(pout), 32'h0);
        check("areset_valid", 32'(pout_valid), 32'h0);
        check("areset_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("areset_no_pulse", 32'(pout_valid), 32'h0);
        mode = 1'b1;
        bits = 4'b0110;
        for (int i = 3; i >= 1; i--) begin
            cyc(1'b1, bits[i]);
            check("areset_fresh_novalid", 32'(pout_valid), 32'h0);
        end
        cyc(1'b1, bits[0]);
        check("areset_valid_after", 32'(pout_valid), 32'h1);
        check("areset_pout_after", 32'(pout), 32'h6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
